// File: rtl/video_pkg.sv
// Shared definitions for the video tone mapper: output mode encodings,
// default luma weights and the fixed-point rounding constants.
package video_pkg;

    typedef enum logic [2:0] {
        MODE_COLOUR = 3'd0,
        MODE_GREEN  = 3'd1,
        MODE_AMBER  = 3'd2,
        MODE_WHITE  = 3'd3,
        MODE_TINT   = 3'd4
    } mode_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    localparam int KR_DEFAULT  = 54;
    localparam int KG_DEFAULT  = 183;
    localparam int KB_DEFAULT  = 19;
    localparam int ROUND_CONST = 128;
    localparam int FRAC_SHIFT  = 8;

    // Unassigned request codes fall back to plain colour.
    function automatic mode_t sanitize_mode(input logic [2:0] req);
        return (req > 3'd4) ? MODE_COLOUR : mode_t'(req);
    endfunction

endpackage

// File: rtl/luma_calc.sv
// Stages 1-2 of the tone mapper: register RGB, weight and sum with rounding,
// saturate to CW bits. The source RGB travels alongside Y with the same delay.
module luma_calc
    import video_pkg::*;
#(
    parameter int CW = 6,
    parameter int KR = KR_DEFAULT,
    parameter int KG = KG_DEFAULT,
    parameter int KB = KB_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] r,
    input  logic [CW-1:0] g,
    input  logic [CW-1:0] b,
    output logic [CW-1:0] y,
    output logic [CW-1:0] r_d,
    output logic [CW-1:0] g_d,
    output logic [CW-1:0] b_d
);

    localparam int PW = CW + 8;
    localparam int SW = CW + 10;
    localparam int YW = SW - FRAC_SHIFT;

    logic [CW-1:0] r_s1, g_s1, b_s1;
    logic [PW-1:0] pr, pg, pb;
    logic [SW-1:0] sum;
    logic [YW-1:0] y_full;
    logic [CW-1:0] y_sat;

    always_comb begin
        pr     = PW'(KR) * PW'(r_s1);
        pg     = PW'(KG) * PW'(g_s1);
        pb     = PW'(KB) * PW'(b_s1);
        sum    = SW'(pr) + SW'(pg) + SW'(pb) + SW'(ROUND_CONST);
        y_full = YW'(sum >> FRAC_SHIFT);
        // Overflow past CW bits only happens when the weights add up to more than 1.0.
        y_sat  = (y_full > YW'({CW{1'b1}})) ? {CW{1'b1}} : y_full[CW-1:0];
    end

    // NOTE: pipeline state uses non-blocking assignments so every stage samples
    // the previous stage's value from before this edge, not the freshly updated one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= '0;
            g_s1 <= '0;
            b_s1 <= '0;
            y    <= '0;
            r_d  <= '0;
            g_d  <= '0;
            b_d  <= '0;
        end else begin
            r_s1 <= r;
            g_s1 <= g;
            b_s1 <= b;
            y    <= y_sat;
            r_d  <= r_s1;
            g_d  <= g_s1;
            b_d  <= b_s1;
        end
    end

endmodule

// File: rtl/video_tone_mapper.sv
// Per-pixel colour-mode processor in front of the VGA DAC: luma pipeline, mode
// mux with frame-synchronous mode/tint shadows, and sync delay lines (3 clocks).
module video_tone_mapper
    import video_pkg::*;
#(
    parameter int CW     = 6,
    parameter int KR     = KR_DEFAULT,
    parameter int KG     = KG_DEFAULT,
    parameter int KB     = KB_DEFAULT,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [2:0]    MODE_IN,
    input  logic [CW-1:0] TINT_R,
    input  logic [CW-1:0] TINT_G,
    input  logic [CW-1:0] TINT_B,
    input  logic [CW-1:0] R_IN,
    input  logic [CW-1:0] G_IN,
    input  logic [CW-1:0] B_IN,
    input  logic          HS_IN,
    input  logic          VS_IN,
    input  logic          DE_IN,
    output logic [CW-1:0] R_OUT,
    output logic [CW-1:0] G_OUT,
    output logic [CW-1:0] B_OUT,
    output logic          HS_OUT,
    output logic          VS_OUT,
    output logic          DE_OUT,
    output logic [2:0]    MODE_ACTIVE
);

    localparam int    TW        = 2 * CW + 1;
    localparam sync_t SYNC_IDLE = '{hs: ~HS_POL, vs: ~VS_POL, de: 1'b0};

    sync_t         sync_s1, sync_s2;
    logic [CW-1:0] y, r_d, g_d, b_d;
    mode_t         mode_shadow;
    logic [CW-1:0] tint_r, tint_g, tint_b;
    logic          frame_edge;
    logic [CW-1:0] r_map, g_map, b_map;

    // T = all ones scales by exactly 1.0, so the default tint is transparent.
    function automatic logic [CW-1:0] tint_scale(input logic [CW-1:0] luma,
                                                 input logic [CW-1:0] tint);
        logic [TW-1:0] prod;
        prod = TW'(luma) * (TW'(tint) + TW'(1));
        return CW'(prod >> CW);
    endfunction

    luma_calc #(
        .CW (CW),
        .KR (KR),
        .KG (KG),
        .KB (KB)
    ) u_luma_calc (
        .clk   (CLK),
        .reset (RESET),
        .r     (R_IN),
        .g     (G_IN),
        .b     (B_IN),
        .y     (y),
        .r_d   (r_d),
        .g_d   (g_d),
        .b_d   (b_d)
    );

    // NOTE: reset is sampled on the clock edge only; RESET is not in the sensitivity list.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_s1 <= SYNC_IDLE;
            sync_s2 <= SYNC_IDLE;
        end else begin
            sync_s1 <= '{hs: HS_IN, vs: VS_IN, de: DE_IN};
            sync_s2 <= sync_s1;
        end
    end

    // VS going active is seen on the registered copies, so the shadows load in
    // time for the pixel that carried the edge to be the first one remapped.
    assign frame_edge = (sync_s1.vs == VS_POL) && (sync_s2.vs != VS_POL);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            mode_shadow <= MODE_COLOUR;
            tint_r      <= '1;
            tint_g      <= '1;
            tint_b      <= '1;
        end else if (frame_edge) begin
            mode_shadow <= sanitize_mode(MODE_IN);
            tint_r      <= TINT_R;
            tint_g      <= TINT_G;
            tint_b      <= TINT_B;
        end
    end

    assign MODE_ACTIVE = mode_shadow;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        r_map = '0;
        g_map = '0;
        b_map = '0;
        if (sync_s2.de) begin
            case (mode_shadow)
                MODE_GREEN: g_map = y;
                MODE_AMBER: begin
                    r_map = y;
                    g_map = y >> 1;
                end
                MODE_WHITE: begin
                    r_map = y;
                    g_map = y;
                    b_map = y;
                end
                MODE_TINT: begin
                    r_map = tint_scale(y, tint_r);
                    g_map = tint_scale(y, tint_g);
                    b_map = tint_scale(y, tint_b);
                end
                default: begin
                    r_map = r_d;
                    g_map = g_d;
                    b_map = b_d;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            R_OUT  <= '0;
            G_OUT  <= '0;
            B_OUT  <= '0;
            HS_OUT <= SYNC_IDLE.hs;
            VS_OUT <= SYNC_IDLE.vs;
            DE_OUT <= 1'b0;
        end else begin
            R_OUT  <= r_map;
            G_OUT  <= g_map;
            B_OUT  <= b_map;
            HS_OUT <= sync_s2.hs;
            VS_OUT <= sync_s2.vs;
            DE_OUT <= sync_s2.de;
        end
    end

endmodule

// File: tb/tb_video_tone_mapper.sv
// Bench for video_tone_mapper: directed literal cases plus randomized frames,
// with a sample-history reference model checked every cycle on two weight sets.
module tb_video_tone_mapper;

    localparam int CW   = 6;
    localparam int MAXY = (1 << CW) - 1;
    localparam int MAXC = 8192;

    typedef struct packed {
        logic          rst;
        logic [2:0]    mode;
        logic [CW-1:0] tr, tg, tb;
        logic [CW-1:0] r, g, b;
        logic          hs, vs, de;
    } sample_t;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [2:0]    MODE_IN;
    logic [CW-1:0] TINT_R, TINT_G, TINT_B;
    logic [CW-1:0] R_IN, G_IN, B_IN;
    logic          HS_IN, VS_IN, DE_IN;

    logic [CW-1:0] a_r, a_g, a_b, w_r, w_g, w_b;
    logic          a_hs, a_vs, a_de, w_hs, w_vs, w_de;
    logic [2:0]    a_mode, w_mode;

    int      checks   = 0;
    int      failures = 0;
    int      cyc      = 0;
    sample_t hist [MAXC];
    int      m_mode   = 0;
    int      m_tr     = MAXY;
    int      m_tg     = MAXY;
    int      m_tb     = MAXY;

    always #5 CLK = ~CLK;

    video_tone_mapper #(.CW(CW)) dut_a (
        .CLK (CLK), .RESET (RESET), .MODE_IN (MODE_IN),
        .TINT_R (TINT_R), .TINT_G (TINT_G), .TINT_B (TINT_B),
        .R_IN (R_IN), .G_IN (G_IN), .B_IN (B_IN),
        .HS_IN (HS_IN), .VS_IN (VS_IN), .DE_IN (DE_IN),
        .R_OUT (a_r), .G_OUT (a_g), .B_OUT (a_b),
        .HS_OUT (a_hs), .VS_OUT (a_vs), .DE_OUT (a_de),
        .MODE_ACTIVE (a_mode)
    );

    video_tone_mapper #(.CW(CW), .KR(128), .KG(128), .KB(128)) dut_w (
        .CLK (CLK), .RESET (RESET), .MODE_IN (MODE_IN),
        .TINT_R (TINT_R), .TINT_G (TINT_G), .TINT_B (TINT_B),
        .R_IN (R_IN), .G_IN (G_IN), .B_IN (B_IN),
        .HS_IN (HS_IN), .VS_IN (VS_IN), .DE_IN (DE_IN),
        .R_OUT (w_r), .G_OUT (w_g), .B_OUT (w_b),
        .HS_OUT (w_hs), .VS_OUT (w_vs), .DE_OUT (w_de),
        .MODE_ACTIVE (w_mode)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, got, exp);
        end
    endtask

    // Record exactly what the DUT samples on each rising edge.
    always @(posedge CLK) begin
        if (cyc < MAXC)
            hist[cyc] <= '{rst: RESET, mode: MODE_IN, tr: TINT_R, tg: TINT_G, tb: TINT_B,
                           r: R_IN, g: G_IN, b: B_IN, hs: HS_IN, vs: VS_IN, de: DE_IN};
        cyc <= cyc + 1;
    end

    function automatic sample_t hist_at(input int k);
        sample_t s;
        s = '0;
        if (k < 0) begin
            s.rst = 1'b1;
            s.hs  = 1'b1;
            s.vs  = 1'b1;
        end else begin
            s = hist[k];
        end
        return s;
    endfunction

    function automatic logic [3*CW-1:0] map_px(input int kr, input int kg, input int kb,
                                                input sample_t s, input int mode,
                                                input int tr, input int tg, input int tb);
        int y, ro, go, bo;
        y = (kr * int'(s.r) + kg * int'(s.g) + kb * int'(s.b) + 128) / 256;
        if (y > MAXY) y = MAXY;
        ro = 0;
        go = 0;
        bo = 0;
        if (s.de) begin
            case (mode)
                1: go = y;
                2: begin ro = y; go = y / 2; end
                3: begin ro = y; go = y; bo = y; end
                4: begin
                    ro = (y * (tr + 1)) / (1 << CW);
                    go = (y * (tg + 1)) / (1 << CW);
                    bo = (y * (tb + 1)) / (1 << CW);
                end
                default: begin ro = int'(s.r); go = int'(s.g); bo = int'(s.b); end
            endcase
        end
        return {CW'(ro), CW'(go), CW'(bo)};
    endfunction

    // Output after edge j shows pixel j-2 with the mode held after edge j-1.
    always @(negedge CLK) begin
        int              j;
        sample_t         sj, sp, spp;
        logic [3*CW-1:0] px_a, px_w;
        logic [2:0]      syn;
        if (cyc >= 1 && cyc <= MAXC) begin
            j   = cyc - 1;
            sj  = hist_at(j);
            sp  = hist_at(j - 1);
            spp = hist_at(j - 2);
            if (sj.rst || sp.rst || spp.rst) begin
                px_a = '0;
                px_w = '0;
                syn  = 3'b110;
            end else begin
                px_a = map_px(54, 183, 19, spp, m_mode, m_tr, m_tg, m_tb);
                px_w = map_px(128, 128, 128, spp, m_mode, m_tr, m_tg, m_tb);
                syn  = {spp.hs, spp.vs, spp.de};
            end
            if (sj.rst) begin
                m_mode = 0;
                m_tr   = MAXY;
                m_tg   = MAXY;
                m_tb   = MAXY;
            end else if (!sp.rst && !sp.vs && (spp.rst || spp.vs)) begin
                m_mode = (sj.mode > 3'd4) ? 0 : int'(sj.mode);
                m_tr   = int'(sj.tr);
                m_tg   = int'(sj.tg);
                m_tb   = int'(sj.tb);
            end
            check("model_a", {a_r, a_g, a_b, a_hs, a_vs, a_de, a_mode}, {px_a, syn, 3'(m_mode)});
            check("model_w", {w_r, w_g, w_b, w_hs, w_vs, w_de, w_mode}, {px_w, syn, 3'(m_mode)});
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pixel(input int r, input int g, input int b, input logic de);
        R_IN  = CW'(r);
        G_IN  = CW'(g);
        B_IN  = CW'(b);
        DE_IN = de;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            DE_IN = 1'b0;
            tick();
        end
    endtask

    task automatic frame_edge(input int mode, input int tr, input int tg, input int tb);
        MODE_IN = 3'(mode);
        TINT_R  = CW'(tr);
        TINT_G  = CW'(tg);
        TINT_B  = CW'(tb);
        DE_IN   = 1'b0;
        VS_IN   = 1'b0;
        tick();
        tick();
        VS_IN   = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        RESET   = 1'b1;
        MODE_IN = 3'd0;
        TINT_R  = '0;
        TINT_G  = '0;
        TINT_B  = '0;
        R_IN    = '0;
        G_IN    = '0;
        B_IN    = '0;
        HS_IN   = 1'b1;
        VS_IN   = 1'b1;
        DE_IN   = 1'b0;
        idle(3);
        check("reset_state", {a_r, a_g, a_b, a_hs, a_vs, a_de, a_mode}, {18'd0, 3'b110, 3'd0});
        RESET = 1'b0;
        idle(2);

        // Green phosphor; full white has Y = 63 under both weight sets.
        frame_edge(1, 5, 5, 5);
        check("mode1_active", 32'(a_mode), 32'd1);
        pixel(63, 63, 63, 1'b1);
        idle(2);
        check("mode1_px", {a_r, a_g, a_b}, {6'd0, 6'd63, 6'd0});
        check("mode1_px_w", {w_r, w_g, w_b}, {6'd0, 6'd63, 6'd0});

        // Amber: Y = (3402 + 128) >> 8 = 13; heavy weights give 32.
        frame_edge(2, 0, 0, 0);
        pixel(63, 0, 0, 1'b1);
        idle(2);
        check("mode2_px", {a_r, a_g, a_b}, {6'd13, 6'd6, 6'd0});
        check("mode2_px_w", {w_r, w_g, w_b}, {6'd32, 6'd16, 6'd0});

        // Tint latched at the frame edge; a mid-frame tint change is ignored.
        frame_edge(4, 63, 31, 0);
        pixel(63, 63, 63, 1'b1);
        idle(2);
        check("mode4_px", {a_r, a_g, a_b}, {6'd63, 6'd31, 6'd0});
        TINT_R = '0;
        TINT_G = '0;
        TINT_B = 6'd63;
        pixel(63, 63, 63, 1'b1);
        idle(2);
        check("mode4_hold", {a_r, a_g, a_b}, {6'd63, 6'd31, 6'd0});

        // Colour passes through until the next frame edge applies white mono.
        frame_edge(0, 0, 0, 0);
        pixel(10, 20, 30, 1'b1);
        idle(2);
        check("mode0_px", {a_r, a_g, a_b}, {6'd10, 6'd20, 6'd30});
        MODE_IN = 3'd3;
        pixel(10, 20, 30, 1'b1);
        idle(2);
        check("mode0_hold", {a_r, a_g, a_b, a_mode}, {6'd10, 6'd20, 6'd30, 3'd0});
        frame_edge(3, 0, 0, 0);
        pixel(10, 20, 30, 1'b1);
        idle(2);
        check("mode3_px", {a_r, a_g, a_b}, {6'd19, 6'd19, 6'd19});
        check("mode3_px_w", {w_r, w_g, w_b}, {6'd30, 6'd30, 6'd30});
        pixel(63, 63, 63, 1'b1);
        idle(2);
        check("sat_w", {w_r, w_g, w_b}, {6'd63, 6'd63, 6'd63});

        // Blanked pixels are black regardless of mode.
        pixel(40, 40, 40, 1'b0);
        idle(2);
        check("blank_mode3", {a_r, a_g, a_b}, 18'd0);
        frame_edge(0, 0, 0, 0);
        pixel(40, 40, 40, 1'b0);
        idle(2);
        check("blank_mode0", {a_r, a_g, a_b}, 18'd0);

        // Reset mid-line with pixels in flight.
        frame_edge(2, 0, 0, 0);
        HS_IN = 1'b0;
        pixel(50, 50, 50, 1'b1);
        pixel(50, 50, 50, 1'b1);
        RESET = 1'b1;
        tick();
        check("reset_midline", {a_r, a_g, a_b, a_hs, a_vs, a_de, a_mode}, {18'd0, 3'b110, 3'd0});
        RESET = 1'b0;
        HS_IN = 1'b1;
        idle(3);

        // Randomized frames: lines of 40, frames of 97, sporadic mode/tint/reset.
        for (int i = 0; i < 2500; i++) begin
            RESET = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 15) == 0) MODE_IN = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) begin
                TINT_R = CW'($urandom);
                TINT_G = CW'($urandom);
                TINT_B = CW'($urandom);
            end
            VS_IN = ((i % 97) < 3) ? 1'b0 : 1'b1;
            HS_IN = ((i % 40) >= 32 && (i % 40) < 36) ? 1'b0 : 1'b1;
            DE_IN = ((i % 40) < 30 && (i % 97) >= 6) ? ($urandom_range(0, 9) != 0) : 1'b0;
            R_IN  = CW'($urandom);
            G_IN  = CW'($urandom);
            B_IN  = CW'($urandom);
            tick();
        end
        RESET = 1'b0;
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
